cmp_arbiter: RTL
================

# cmp_arbiter

Round-robin arbiter and sequencer that shares one 8-bit magnitude comparator (`Comparator8Bit`) among several calculator requesters. Each requester presents an operand pair and a request. The block grants one requester at a time, latches its operands, registers the eq/lt/gt result and returns it with a one-cycle acknowledge. It sits between the calculator's operation units (e.g. compare, min/max, branch logic) and the single shared comparator instance.

## Interface

**Parameters**
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `IDW`, default 2: width of `grant_id`. Must equal ceil(log2(`NUM_REQ`)).

**Ports**
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req`, input, `NUM_REQ`: per-requester request, level.
- `a_flat`, input, `NUM_REQ`*8: operand A. Requester i uses bits [8i+7:8i].
- `b_flat`, input, `NUM_REQ`*8: operand B, same packing as `a_flat`.
- `ack`, output, `NUM_REQ`: one-hot, one-cycle completion pulse.
- `res_eq`, output, 1: registered A == B for the last completed operation.
- `res_lt`, output, 1: registered A < B (unsigned).
- `res_gt`, output, 1: registered A > B (unsigned).
- `grant_id`, output, `IDW`: index of the current or last granted requester.
- `busy`, output, 1: high in CMP and RESP states.

## Operation

- The FSM has three states:
  - **IDLE**: `busy`=0. On a clock edge where any `req` bit is 1, select a winner, latch its A and B into internal registers, and go to CMP. With no requests, stay in IDLE.
  - **CMP**: the comparator sees the latched operands. On the next edge, register eq/lt/gt into `res_*`, set `ack[winner]`=1, and go to RESP.
  - **RESP**: `ack` is high for exactly this cycle. On the next edge, clear `ack`, advance the pointer, and go to IDLE unconditionally.
- Arbitration is round-robin:
  - A priority pointer `ptr` resets to 0.
  - The winner is the first set `req` bit searching `ptr`, `ptr`+1, … `NUM_REQ`-1, 0, … `ptr`-1.
  - After a grant to index w, `ptr` becomes (w+1) mod `NUM_REQ`.
- Comparison is unsigned, 8 bits. After the first completed operation, exactly one of `res_eq`, `res_lt`, `res_gt` is 1.
- Operands are latched in IDLE. Requester inputs may change after the grant edge without affecting the result.
- `req` dropped during CMP: the operation still completes and `ack` still pulses. No cancel exists.
- Requester handshake rule:
  - Hold `req` and operands stable until `ack` is seen.
  - `req` must be low at the edge ending RESP+1; otherwise the requester is treated as a new request.
- `res_*` and `grant_id` hold their values until the next CMP→RESP edge. `grant_id` updates at the IDLE→CMP edge.
- Reset (asynchronous, any state) has these effects:
  - State goes to IDLE and `ptr` to 0.
  - `ack`=0, `res_eq`=`res_lt`=`res_gt`=0, `grant_id`=0, `busy`=0.
  - An in-flight operation is discarded and no `ack` is issued.

## Timing

- Request sampled at edge E0 (state IDLE) gives:
  - CMP during E0..E1;
  - `ack` and valid `res_*` during E1..E2;
  - IDLE during E2..E3;
  - next grant no earlier than E3.
- Latency from the sampling edge to `ack` is 1 cycle of CMP plus the registered output: `ack` is visible 2 cycles after `req` is first high.
- Throughput is one operation per 3 cycles under continuous contention.
- Simultaneous requests are resolved only by `ptr`. Ties are impossible because the grant is one-hot.
- `ack` is never high for two consecutive cycles and never high for more than one bit.
- The comparator path is combinational, from the operand registers to the `res_*` registers, within one cycle.

## Test plan

- **Reset values**: assert `rst_n`=0 mid-CMP with req[1]=1 → `ack`=0 throughout, `res_*`=0, `busy`=0, `grant_id`=0. After release, req[1] is re-granted from IDLE.
- **Single request**: req[2]=1, A=0x5A, B=0xA5, sampled at E0 → `ack`=4'b0100 exactly during E1..E2, `res_lt`=1, `res_eq`=`res_gt`=0, `grant_id`=2.
- **Equal and greater operands**:
  - A=0xFF, B=0xFF → `res_eq`=1.
  - A=0x80, B=0x7F → `res_gt`=1. This covers the high-nibble decision.
  - A=0x1F, B=0x10 → `res_gt`=1. This covers the low-nibble decision with equal high nibble.
- **Full contention**: req=4'b1111 held high, each requester dropping `req` after its `ack` → grant order 0,1,2,3, with `ack` pulses 3 cycles apart.
- **Round-robin fairness**: ptr=2 after granting 1; req=4'b0011 → grant goes to 0, then 1. Requester 3 arriving while 0 is in CMP is granted before 1 only if `ptr` reaches it first. Check `ptr`=1 → grant 1 before 3.
- **Operand change and drop**:
  - After the grant edge, change `a_flat` for the winner → `res_*` reflects the latched values.
  - Drop `req` during CMP → `ack` still pulses once.

Source files
------------

// File: rtl/cmp_arbiter.sv
// ---------------------------------------------------------------------------
// cmp_arbiter
//   Round-robin arbiter/sequencer sharing one 8-bit unsigned magnitude
//   comparator among NUM_REQ calculator requesters. One operation takes
//   three cycles: IDLE (grant + operand latch), CMP (compare), RESP (ack).
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req       : per-requester level request
//   a_flat    : operand A, requester i on bits [8i+7:8i]
//   b_flat    : operand B, same packing as a_flat
//   ack       : one-hot, one-cycle completion pulse
//   res_eq    : registered A == B of the last completed operation
//   res_lt    : registered A <  B (unsigned)
//   res_gt    : registered A >  B (unsigned)
//   grant_id  : index of the current or last granted requester
//   busy      : high while in CMP or RESP
// ---------------------------------------------------------------------------

// Comparator8Bit
//   Combinational 8-bit unsigned magnitude comparator built from two nibble
//   compares: the high nibble decides unless equal, then the low nibble.
//   Ports: a, b (operands); eq, lt, gt (exactly one is high).
module Comparator8Bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       eq,
  output logic       lt,
  output logic       gt
);
  logic hi_eq, hi_lt, hi_gt;
  logic lo_eq, lo_lt, lo_gt;

  always_comb begin
    hi_eq = (a[7:4] == b[7:4]);
    hi_lt = (a[7:4] <  b[7:4]);
    hi_gt = (a[7:4] >  b[7:4]);
    lo_eq = (a[3:0] == b[3:0]);
    lo_lt = (a[3:0] <  b[3:0]);
    lo_gt = (a[3:0] >  b[3:0]);
    eq    = hi_eq & lo_eq;
    lt    = hi_lt | (hi_eq & lo_lt);
    gt    = hi_gt | (hi_eq & lo_gt);
  end
endmodule

module cmp_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] a_flat,
  input  logic [NUM_REQ*8-1:0] b_flat,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 res_eq,
  output logic                 res_lt,
  output logic                 res_gt,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMP,
    ST_RESP
  } state_t;

  state_t             state;
  logic [IDW-1:0]     ptr;
  logic [7:0]         a_q;
  logic [7:0]         b_q;

  logic [NUM_REQ-1:0] rot;
  logic [IDW:0]       cand;
  logic [IDW-1:0]     win;
  logic               found;

  logic               cmp_eq;
  logic               cmp_lt;
  logic               cmp_gt;

  Comparator8Bit u_cmp (
    .a  (a_q),
    .b  (b_q),
    .eq (cmp_eq),
    .lt (cmp_lt),
    .gt (cmp_gt)
  );

  // Rotate requests so bit k is requester (ptr+k) mod NUM_REQ; the first set
  // bit is the winner, mapped back to an absolute index.
  always_comb begin
    rot   = NUM_REQ'({req, req} >> ptr);
    found = 1'b0;
    cand  = '0;
    win   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        cand  = {1'b0, ptr} + (IDW+1)'(k);
        if (cand >= (IDW+1)'(NUM_REQ)) begin
          cand = cand - (IDW+1)'(NUM_REQ);
        end
        win = cand[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ack      <= '0;
      res_eq   <= 1'b0;
      res_lt   <= 1'b0;
      res_gt   <= 1'b0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            a_q      <= a_flat[{win, 3'b000} +: 8];
            b_q      <= b_flat[{win, 3'b000} +: 8];
            grant_id <= win;
            busy     <= 1'b1;
            state    <= ST_CMP;
          end
        end
        ST_CMP: begin
          res_eq <= cmp_eq;
          res_lt <= cmp_lt;
          res_gt <= cmp_gt;
          ack    <= NUM_REQ'(1) << grant_id;
          state  <= ST_RESP;
        end
        ST_RESP: begin
          ack   <= '0;
          busy  <= 1'b0;
          ptr   <= (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + IDW'(1);
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
